// File: rtl/col_parity_pkg.sv
// ----------------------------------------------------------------------------
// col_parity_pkg
// Shared definitions for the column-parity block controller:
//   - NUM_SLICES / ADDR_W : default block geometry (64 slices of 25 bits)
//   - LAST_SLICE          : index of the final slice in a block
//   - state_e             : controller FSM state enumeration
// ----------------------------------------------------------------------------
package col_parity_pkg;

    localparam int NUM_SLICES = 64;
    localparam int ADDR_W     = 6;

    localparam logic [ADDR_W-1:0] LAST_SLICE = ADDR_W'(NUM_SLICES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRE_RD   = 3'd1,
        ST_PRE_WAIT = 3'd2,
        ST_RD       = 3'd3,
        ST_WAIT     = 3'd4,
        ST_WR       = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

endpackage

// File: rtl/col_parity_ctrl_slice_counter.sv
// ----------------------------------------------------------------------------
// slice_counter
// W-bit up-counter holding the current slice index of a block.
//   clk, rst : clock and synchronous active-high reset (clears the count)
//   clr      : synchronous clear, has priority over en
//   en       : advance by one; ignored at terminal count so the index never
//              wraps back to 0 inside a block
//   cnt      : registered count
//   tc       : high while cnt equals LAST
// ----------------------------------------------------------------------------
module slice_counter #(
    parameter int W    = 6,
    parameter int LAST = 63
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] ONE    = W'(1);
    localparam logic [W-1:0] LAST_V = W'(LAST);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         tc_s;

    // Terminal-count decode and next-count selection.
    always_comb begin
        cnt_d = cnt_q;
        tc_s  = (cnt_q == LAST_V);
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (en && !tc_s) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = tc_s;

endmodule

// File: rtl/col_parity_ctrl.sv
// ----------------------------------------------------------------------------
// col_parity_ctrl
// Sequencing controller for a column-parity pass over one block of slices.
// It prefetches the parity of the last slice into the previous-parity
// register, then for every slice z = 0..NUM_SLICES-1 reads the slice, loads
// it into the current-slice register, writes the result for z and moves the
// current parity into the previous-parity register. The controller holds no
// datapath state; it only drives enables, the prev mux select and addresses.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle request to process a block (ignored while busy)
//   rd_valid   : read data valid from the slice memory
//   busy       : high in every state except IDLE
//   done       : one-cycle completion pulse
//   rd_en      : slice-memory read request, rd_addr = slice index (0 when idle)
//   ld_cur     : load enable for the current-slice register
//   ld_prev    : load enable for the previous-parity register
//   prev_sel   : prev mux select, 0 = memory data, 1 = current-slice parity
//   wr_en      : result write strobe, wr_addr = slice index (0 when idle)
// ----------------------------------------------------------------------------
module col_parity_ctrl
    import col_parity_pkg::*;
#(
    parameter int NUM_SLICES = col_parity_pkg::NUM_SLICES,
    parameter int ADDR_W     = col_parity_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              ld_cur,
    output logic              ld_prev,
    output logic              prev_sel,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);

    localparam logic [ADDR_W-1:0] LAST_Z = ADDR_W'(NUM_SLICES - 1);

    state_e            state_q;
    state_e            state_d;

    logic [ADDR_W-1:0] z_s;
    logic              z_tc_s;
    logic              z_clr_s;
    logic              z_inc_s;

    // Slice index; cleared at the prefetch, advanced after each write.
    slice_counter #(
        .W    (ADDR_W),
        .LAST (NUM_SLICES - 1)
    ) u_slice_counter (
        .clk (clk),
        .rst (rst),
        .clr (z_clr_s),
        .en  (z_inc_s),
        .cnt (z_s),
        .tc  (z_tc_s)
    );

    // State register; reset wins over any pending start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode from the current state and rd_valid.
    always_comb begin
        state_d  = state_q;
        busy     = 1'b1;
        done     = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = {ADDR_W{1'b0}};
        ld_cur   = 1'b0;
        ld_prev  = 1'b0;
        prev_sel = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = {ADDR_W{1'b0}};
        z_clr_s  = 1'b0;
        z_inc_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = ST_PRE_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            // Read the last slice so slice 0 has a previous parity.
            ST_PRE_RD: begin
                rd_en   = 1'b1;
                rd_addr = LAST_Z;
                z_clr_s = 1'b1;
                state_d = ST_PRE_WAIT;
            end

            // Prefetched data goes straight from memory into prev.
            ST_PRE_WAIT: begin
                if (rd_valid) begin
                    ld_prev  = 1'b1;
                    prev_sel = 1'b0;
                    state_d  = ST_RD;
                end else begin
                    state_d  = ST_PRE_WAIT;
                end
            end

            ST_RD: begin
                rd_en   = 1'b1;
                rd_addr = z_s;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (rd_valid) begin
                    ld_cur  = 1'b1;
                    state_d = ST_WR;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            // Write result for z and roll current parity into prev for z+1.
            ST_WR: begin
                wr_en    = 1'b1;
                wr_addr  = z_s;
                ld_prev  = 1'b1;
                prev_sel = 1'b1;
                if (z_tc_s) begin
                    state_d = ST_DONE;
                end else begin
                    z_inc_s = 1'b1;
                    state_d = ST_RD;
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_col_parity_ctrl.sv
module tb_col_parity_ctrl;

    localparam int N = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       rd_valid;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [5:0] rd_addr;
    logic       ld_cur;
    logic       ld_prev;
    logic       prev_sel;
    logic       wr_en;
    logic [5:0] wr_addr;

    col_parity_ctrl #(.NUM_SLICES(N), .ADDR_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .ld_cur   (ld_cur),
        .ld_prev  (ld_prev),
        .prev_sel (prev_sel),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       rd_en;
        logic [5:0] rd_addr;
        logic       ld_cur;
        logic       ld_prev;
        logic       prev_sel;
        logic       wr_en;
        logic [5:0] wr_addr;
        logic       done;
    } ev_t;

    ev_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int start_edge = 0;
    int lat_total = 0;
    int lat_base = 0;
    int wr_total = 0;
    int wr_base = 0;
    int done_cnt = 0;
    int lat_mode = 0;
    bit spur_en = 1'b0;

    function automatic ev_t mk(input logic rd, input logic [5:0] ra, input logic lc,
                               input logic lp, input logic ps, input logic wr,
                               input logic [5:0] wa, input logic dn);
        ev_t e;
        e.rd_en = rd; e.rd_addr = ra; e.ld_cur = lc; e.ld_prev = lp;
        e.prev_sel = ps; e.wr_en = wr; e.wr_addr = wa; e.done = dn;
        return e;
    endfunction

    // Expected transaction list of one complete block.
    task automatic push_block();
        exp_q.push_back(mk(1'b1, 6'd63, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0));
        exp_q.push_back(mk(1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0));
        for (int z = 0; z < N; z++) begin
            exp_q.push_back(mk(1'b1, 6'(z), 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0));
            exp_q.push_back(mk(1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0));
            exp_q.push_back(mk(1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1, 6'(z), 1'b0));
        end
        exp_q.push_back(mk(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1));
    endtask

    // Memory responder: rd_valid L cycles after each read, optional spurious pulses.
    initial begin
        int due;
        int l;
        due = 0;
        rd_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rd_valid = 1'b0;
            if (due > 0) begin
                due--;
                if (due == 0) rd_valid = 1'b1;
            end else if (spur_en && ($urandom_range(0, 2) == 0)) begin
                rd_valid = 1'b1;
            end
            if (rd_en) begin
                case (lat_mode)
                    0: l = 1;
                    1: l = 3;
                    default: l = int'($urandom_range(1, 4));
                endcase
                due = l;
                lat_total = lat_total + l - 1;
            end
        end
    end

    // Monitor: every strobe cycle must match the next expected transaction.
    always @(negedge clk) begin
        ev_t act;
        ev_t e;
        int k;
        act = '{rd_en, rd_addr, ld_cur, ld_prev, prev_sel, wr_en, wr_addr, done};
        if (act.rd_en || act.ld_cur || act.ld_prev || act.wr_en || act.done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe got=%05h at cycle %0d", act, cyc);
            end else begin
                e = exp_q.pop_front();
                if (!e.ld_prev) begin
                    e.prev_sel = 1'b0;
                    act.prev_sel = 1'b0;
                end
                if (act != e) begin
                    errors++;
                    $display("FAIL strobe_seq got=%05h exp=%05h at cycle %0d", act, e, cyc);
                end
            end
            if (wr_en) wr_total++;
            if (done) begin
                k = cyc - start_edge + 1;
                checks++;
                if (k != 195 + (lat_total - lat_base)) begin
                    errors++;
                    $display("FAIL done_cycle got=%0d exp=%0d", k, 195 + (lat_total - lat_base));
                end
                checks++;
                if (wr_total - wr_base != N) begin
                    errors++;
                    $display("FAIL wr_count got=%0d exp=%0d", wr_total - wr_base, N);
                end
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_in_done got=%b exp=1", busy);
                end
                done_cnt++;
            end
        end else begin
            checks++;
            if (rd_addr !== 6'd0 || wr_addr !== 6'd0) begin
                errors++;
                $display("FAIL addr_when_idle rd_addr=%0d wr_addr=%0d exp=0", rd_addr, wr_addr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        start_edge = cyc + 1;
        lat_base = lat_total;
        wr_base = wr_total;
        push_block();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input bit rnd_start);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            start = rnd_start && ($urandom_range(0, 15) == 0);
            tick();
            n++;
        end
        start = 1'b0;
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s done_timeout got=no_done exp=done within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_wr(input int z, input int budget);
        int n;
        n = 0;
        while (!(wr_en && wr_addr == 6'(z)) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (!(wr_en && wr_addr == 6'(z))) begin
            errors++;
            $display("FAIL wait_wr%0d got=timeout exp=wr_en at slice %0d", z, z);
        end
    endtask

    // Checks the DUT is idle with all outputs low; consumes one cycle.
    task automatic check_idle(input string name);
        @(negedge clk);
        checks++;
        if (busy || done || rd_en || ld_cur || ld_prev || prev_sel || wr_en
            || rd_addr != 6'd0 || wr_addr != 6'd0) begin
            errors++;
            $display("FAIL %s got busy=%b done=%b rd_en=%b ld_cur=%b ld_prev=%b sel=%b wr_en=%b ra=%0d wa=%0d exp=all_zero",
                     name, busy, done, rd_en, ld_cur, ld_prev, prev_sel, wr_en, rd_addr, wr_addr);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        tick();
        tick();
        check_idle("reset_state");
        rst = 1'b0;
        check_idle("post_reset");

        // Nominal block, one-cycle memory latency.
        lat_mode = 0;
        do_start();
        wait_done("blk_lat1", 400, 1'b0);
        check_idle("idle_after_blk1");

        // Every read returns three cycles late.
        lat_mode = 1;
        do_start();
        wait_done("blk_lat3", 600, 1'b0);
        check_idle("idle_after_blk2");

        // Extra start at slice 10 must be dropped.
        lat_mode = 0;
        do_start();
        wait_wr(10, 200);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("blk_restart", 400, 1'b0);
        for (int i = 0; i < 4; i++) check_idle("no_queued_start");

        // Reset while writing slice 30 abandons the block.
        do_start();
        wait_wr(30, 200);
        rst = 1'b1;
        tick();
        exp_q.delete();
        check_idle("in_reset_mid_block");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) check_idle("after_mid_reset");
        do_start();
        wait_done("blk_after_reset", 400, 1'b0);
        check_idle("idle_after_blk4");

        // Random latency, spurious rd_valid and random start pulses while busy.
        spur_en = 1'b1;
        lat_mode = 2;
        for (int i = 0; i < 6; i++) check_idle("idle_spurious");
        for (int b = 0; b < 3; b++) begin
            do_start();
            wait_done("blk_random", 800, 1'b1);
            check_idle("idle_after_random");
        end

        // Reset and start together.
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 4; i++) check_idle("rst_start_same_cycle");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d left exp=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
